uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//   UART transmit stage. Drives the serial line that the receiver (RX_top) samples on its rx_in.
//   Accepts one byte per valid/ready handshake and emits the frame LSB first:
//   start(0), d0..d7, optional parity, stop(1).
//   Also serves as the stimulus source for loopback checks of RX_top.
// PARAMETERS
//   CLKS_PER_BIT  1  clocks per serial bit; legal range >=1; 1 = one bit per clk (RX_top rate)
//   PARITY_EN     1  1: parity bit inserted between d7 and stop; 0: no parity bit
//   PARITY_ODD    0  0: even parity (bit = ^data); 1: odd parity (bit = ~^data)
// PORTS
//   clk         in   1  system clock, rising edge
//   rstn        in   1  asynchronous active-low reset
//   tx_data_in  in   8  byte to send; sampled only on the accept cycle
//   tx_valid    in   1  tx_data_in is valid
//   tx_ready    out  1  block can accept a byte this cycle
//   tx_out      out  1  serial line, idle high
//   tx_busy     out  1  frame in progress (any state except IDLE)
//   tx_done     out  1  one-cycle pulse in the cycle after the last stop-bit clock
// BEHAVIOUR
//   Reset (async, rstn=0):
//     state=IDLE, tx_out=1, tx_ready=1, tx_busy=0, tx_done=0; baud and bit counters = 0.
//     Reset mid-frame aborts the frame immediately. The line returns high, and no tx_done is produced.
//   FSM states: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
//   tx_ready = (state==IDLE); combinational from registered state.
//   Accept: tx_valid && tx_ready at a rising edge.
//     - Latch tx_data_in into an 8-bit shift register.
//     - Latch the parity of tx_data_in.
//     - Go to START.
//     tx_valid while busy is ignored; no data is lost or queued. The source holds until ready.
//   Baud counter:
//     - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
//     - A bit ends when the count is CLKS_PER_BIT-1; the counter then wraps to 0.
//   Line value per state: START=0, DATA=shreg[0], PARITY=latched parity bit, STOP=1, IDLE=1.
//   tx_out is a registered output.
//     - tx_out goes low on the first clock edge after accept (latency 1).
//     - Each bit holds exactly CLKS_PER_BIT clocks.
//   DATA:
//     - A 3-bit index counts 0..7.
//     - Shift right at each bit end.
//     - Leave DATA after index 7 ends.
//   Frame length = CLKS_PER_BIT*(10+PARITY_EN) clocks.
//   tx_done and return to IDLE occur on the same edge that ends the stop bit.
//   IDLE lasts at least 1 clock between frames. Back-to-back frames are therefore separated
//   by one extra idle-high clock.
//   tx_data_in changes after accept do not affect the frame in flight.
//   Parity is computed on the latched byte only.
// TESTING
//   1 Reset:
//     - Assert rstn=0 mid-DATA of a frame -> tx_out=1, tx_busy=0, tx_ready=1 immediately.
//     - No tx_done is produced.
//     - The next accepted byte starts a clean frame.
//   2 Defaults, send 0xC6:
//     - Line sequence 0,0,1,1,0,0,0,1,1,0,1, one bit per clk.
//     - Parity bit = 0; RX_top shows rx_data_out=0xC6 with no parity or stop error.
//   3 PARITY_ODD=1, send 0x01:
//     - Parity bit = 0 (even-parity build: 1).
//     - Frame is 11 bits; tx_done pulses once.
//   4 CLKS_PER_BIT=4, PARITY_EN=0, send 0xA5:
//     - 40-clock frame; each bit stable for 4 clks.
//     - LSB-first data 1,0,1,0,0,1,0,1.
//   5 Handshake:
//     - Hold tx_valid=1 with 0x55 then 0xAA -> second byte accepted only after tx_done.
//     - Exactly one idle-high clock between the frames.
//     - tx_data_in toggled mid-frame does not alter line bits.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts one byte per valid/ready handshake and drives
// start, 8 data bits LSB first, optional parity and stop on an idle-high line.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data_in,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_nx;
  logic [2:0]        r_idx;
  logic [2:0]        w_idx_nx;
  logic [7:0]        r_shreg;
  logic [7:0]        w_shreg_nx;
  logic              r_par;
  logic              w_par_nx;
  logic              r_tx_out;
  logic              w_line_nx;
  logic              r_done;
  logic              w_done_nx;
  logic              w_bit_end;
  logic              w_accept;

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign w_accept  = tx_valid && (r_state == S_IDLE);

  // State and datapath registers; reset aborts any frame and forces the line high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_idx    <= '0;
      r_shreg  <= '0;
      r_par    <= 1'b0;
      r_tx_out <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_baud   <= w_baud_nx;
      r_idx    <= w_idx_nx;
      r_shreg  <= w_shreg_nx;
      r_par    <= w_par_nx;
      r_tx_out <= w_line_nx;
      r_done   <= w_done_nx;
    end
  end

  // Next state, counters, shift register and the line value for the upcoming bit.
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud;
    w_idx_nx   = r_idx;
    w_shreg_nx = r_shreg;
    w_par_nx   = r_par;
    w_line_nx  = 1'b1;
    w_done_nx  = 1'b0;

    if (r_state != S_IDLE) begin
      w_baud_nx = w_bit_end ? '0 : r_baud + BAUD_W'(1);
    end else begin
      w_baud_nx = '0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nx = S_START;
          w_shreg_nx = tx_data_in;
          w_idx_nx   = '0;
          w_par_nx   = (PARITY_ODD != 0) ? ~^tx_data_in : ^tx_data_in;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shreg_nx = {1'b0, r_shreg[7:1]};
          w_idx_nx   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nx = S_IDLE;
          w_done_nx  = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    case (w_state_nx)
      S_START:  w_line_nx = 1'b0;
      S_DATA:   w_line_nx = w_shreg_nx[0];
      S_PARITY: w_line_nx = w_par_nx;
      default:  w_line_nx = 1'b1;
    endcase
  end

  assign tx_ready = (r_state == S_IDLE);
  assign tx_busy  = (r_state != S_IDLE);
  assign tx_out   = r_tx_out;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: three parameter builds driven with random bytes,
// each frame checked clock by clock against a bit-position model of the UART frame.
module tb_uart_tx_serializer;

  typedef struct {
    logic [7:0] d;
    int         acc;
  } frm_t;

  logic clk;
  int   cyc;
  int   n_chk;
  int   n_pass;
  bit   fin [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected line value for bit position k of a frame carrying byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int k, input int pe, input int odd);
    logic [7:0] v;
    int         ones;
    v    = d;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(v[i]);
    if (k == 0) return 1'b0;
    if (k >= 1 && k <= 8) return v[k-1];
    if (k == 9 && pe != 0) return (odd != 0) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input int gi, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cfg%0d cyc=%0d: got %0h expected %0h", nm, gi, cyc, act, exp);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int CPB = (gi == 0) ? 1 : ((gi == 1) ? 4 : 2);
    localparam int PE  = (gi == 1) ? 0 : 1;
    localparam int ODD = (gi == 2) ? 1 : 0;
    localparam int NB  = 10 + PE;
    localparam int N   = CPB * NB;

    logic       rstn;
    logic [7:0] tx_data_in;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;

    frm_t q[$];
    frm_t cur;
    bit   act;
    bit   mon_en;

    uart_tx_serializer #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PE),
      .PARITY_ODD  (ODD)
    ) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .tx_data_in(tx_data_in),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_out    (tx_out),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done)
    );

    // Monitor: compares every clock of each queued frame, then the idle line between frames.
    always @(negedge clk) begin
      int t;
      if (!act && q.size() > 0) begin
        cur = q.pop_front();
        act = 1'b1;
      end
      if (act && cyc >= cur.acc) begin
        t = cyc - cur.acc;
        if (t < N) begin
          chk("line_bit", gi, 32'(tx_out), 32'(exp_bit(cur.d, t / CPB, PE, ODD)));
          chk("busy_in_frame", gi, 32'(tx_busy), 32'd1);
          chk("no_early_done", gi, 32'(tx_done), 32'd0);
        end else begin
          chk("done_pulse", gi, 32'(tx_done), 32'd1);
          chk("line_after_stop", gi, 32'(tx_out), 32'd1);
          chk("idle_after_frame", gi, 32'(tx_busy), 32'd0);
          act = 1'b0;
        end
      end else if (!act && mon_en && rstn) begin
        chk("idle_done", gi, 32'(tx_done), 32'd0);
        chk("idle_line", gi, 32'(tx_out), 32'd1);
        chk("idle_ready", gi, 32'(tx_ready), 32'd1);
      end
    end

    task automatic wait_ready();
      for (int w = 0; w < 4 * N && !tx_ready; w++) @(negedge clk);
      chk("accept_ready", gi, 32'(tx_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] d);
      @(negedge clk);
      tx_valid   = 1'b1;
      tx_data_in = d;
      wait_ready();
      q.push_back('{d: d, acc: cyc + 1});
      @(negedge clk);
      tx_valid   = 1'b0;
      tx_data_in = 8'($urandom);
    endtask

    task automatic drain();
      for (int w = 0; w < 4 * N && (q.size() > 0 || act); w++) @(negedge clk);
      chk("drain", gi, 32'(q.size() + int'(act)), 32'd0);
    endtask

    initial begin
      int a1;
      int a2;
      rstn       = 1'b0;
      tx_valid   = 1'b0;
      tx_data_in = 8'h00;
      mon_en     = 1'b0;
      act        = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", gi, 32'(tx_ready), 32'd1);
      chk("rst_busy", gi, 32'(tx_busy), 32'd0);
      chk("rst_line", gi, 32'(tx_out), 32'd1);
      chk("rst_done", gi, 32'(tx_done), 32'd0);
      rstn   = 1'b1;
      mon_en = 1'b1;

      send(8'hC6);
      send(8'h01);
      send(8'hA5);
      drain();

      // Reset in the middle of the data bits; the aborted frame must not pulse done.
      mon_en = 1'b0;
      @(negedge clk);
      tx_valid   = 1'b1;
      tx_data_in = 8'($urandom);
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      chk("pre_rst_busy", gi, 32'(tx_busy), 32'd1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_line", gi, 32'(tx_out), 32'd1);
      chk("mid_rst_busy", gi, 32'(tx_busy), 32'd0);
      chk("mid_rst_ready", gi, 32'(tx_ready), 32'd1);
      chk("mid_rst_done", gi, 32'(tx_done), 32'd0);
      repeat (2) @(negedge clk);
      rstn   = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      send(8'($urandom));
      drain();

      // Held valid across two frames with data wiggling during the first one.
      @(negedge clk);
      tx_valid   = 1'b1;
      tx_data_in = 8'h55;
      wait_ready();
      a1 = cyc + 1;
      q.push_back('{d: 8'h55, acc: a1});
      for (int k = 0; k <= N - 3; k++) begin
        @(negedge clk);
        tx_data_in = 8'($urandom);
      end
      @(negedge clk);
      tx_data_in = 8'hAA;
      wait_ready();
      a2 = cyc + 1;
      q.push_back('{d: 8'hAA, acc: a2});
      chk("b2b_gap", gi, 32'(a2 - a1), 32'(N + 1));
      @(negedge clk);
      tx_valid = 1'b0;
      drain();

      for (int f = 0; f < 20; f++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(8'($urandom));
      end
      drain();
      fin[gi] = 1'b1;
    end
  end

  initial begin
    bit all;
    all = 1'b0;
    for (int w = 0; w < 20000 && !all; w++) begin
      @(negedge clk);
      all = fin[0] && fin[1] && fin[2];
    end
    if (!all) begin
      n_chk++;
      $display("FAIL timeout: got unfinished builds expected all finished");
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
